// File: rtl/hbm_arb_pkg.sv
// rtl/hbm_arb_pkg.sv - shared constants, read-return entry type and round-robin helper
// Contents:
//   CMD_RD_BIT     command bit that marks a read (1) or a write (0)
//   ARB_NUM_REQ    default requester count
//   ARB_DATA_W     default data width
//   ARB_TAG_W      requester tag width for the default requester count
//   rd_entry_t     {tag, data} entry held by the read-data FIFO
//   rr_find_first  first set bit at or after a pointer, wrapping; -1 when none
package hbm_arb_pkg;

  localparam int CMD_RD_BIT  = 24;
  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_DATA_W  = 1024;
  localparam int ARB_TAG_W   = $clog2(ARB_NUM_REQ);

  typedef struct packed {
    logic [ARB_TAG_W-1:0]  tag;
    logic [ARB_DATA_W-1:0] data;
  } rd_entry_t;

  // Walks from the farthest candidate back to the pointer so the last hit,
  // which is the closest one at or after the pointer, wins.
  function automatic int rr_find_first(input logic [7:0] elig, input int ptr, input int n);
    int res;
    int idx;
    res = -1;
    for (int k = 7; k >= 0; k--) begin
      idx = (ptr + k) % n;
      if (k < n && elig[idx]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/hbm_arb_fifo.sv
// rtl/hbm_arb_fifo.sv - show-ahead synchronous FIFO with simultaneous push/pop
// Ports:
//   clk, rst     clock, asynchronous active-high reset (clears pointers only)
//   push, din    write request and data; accepted when not full or when popping
//   pop          read request; ignored when empty
//   dout         head entry, valid while !empty
//   full, empty  occupancy flags
module hbm_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the slot indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hbm_cmd_arbiter.sv
// rtl/hbm_cmd_arbiter.sv - round-robin HBM command arbiter with in-order read return routing
// Optional feature macro: HBM_ARB_STATS_EN (adds o_stats, one 32-bit accept counter per requester)
// Ports:
//   ap_clk, ap_rst                      clock, asynchronous active-high reset
//   s_axis_wr_tvalid/tready/tuser/tdata per-requester command streams (tuser = command, tdata = write data)
//   i_controller_ready                  controller accepts the registered command
//   o_command_valid/o_command/o_write_data  registered command stage toward the controller
//   i_read_data_valid, i_read_data      controller read beats, no backpressure
//   m_axis_rd_tvalid/tready/tdata/tkeep/tlast  read data routed back to the issuing requester
//   o_err                               sticky: read beat arrived with no outstanding read
//   o_stats                             per-requester accept counters (HBM_ARB_STATS_EN only)
module hbm_cmd_arbiter
  import hbm_arb_pkg::*;
#(
  parameter int NUM_REQ  = ARB_NUM_REQ,
  parameter int CMD_W    = 25,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int RD_DEPTH = 8
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_REQ-1:0]        s_axis_wr_tvalid,
  output logic [NUM_REQ-1:0]        s_axis_wr_tready,
  input  logic [NUM_REQ*CMD_W-1:0]  s_axis_wr_tuser,
  input  logic [NUM_REQ*DATA_W-1:0] s_axis_wr_tdata,
  input  logic                      i_controller_ready,
  output logic                      o_command_valid,
  output logic [CMD_W-1:0]          o_command,
  output logic [DATA_W-1:0]         o_write_data,
  input  logic                      i_read_data_valid,
  input  logic [DATA_W-1:0]         i_read_data,
  output logic [NUM_REQ-1:0]        m_axis_rd_tvalid,
  input  logic [NUM_REQ-1:0]        m_axis_rd_tready,
  output logic [DATA_W-1:0]         m_axis_rd_tdata,
  output logic [DATA_W/8-1:0]       m_axis_rd_tkeep,
  output logic                      m_axis_rd_tlast,
  output logic                      o_err
`ifdef HBM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     o_stats
`endif
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CRW   = $clog2(RD_DEPTH + 1);

  logic               load;
  logic               accept;
  logic               found;
  logic               has_credit;
  logic               sel_is_rd;
  logic               rd_inc;
  logic               rd_dec;
  int                 pick;
  logic [TAG_W-1:0]   ptr;
  logic [TAG_W-1:0]   gidx;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [CMD_W-1:0]   sel_cmd;
  logic [DATA_W-1:0]  sel_data;
  logic [CRW-1:0]     credits;

  logic               tag_push;
  logic               tag_pop;
  logic [TAG_W-1:0]   tag_dout;
  logic               tag_full;
  logic               tag_empty;
  logic               rd_pop;
  logic               rd_full;
  logic               rd_empty;
  rd_entry_t          rd_din;
  rd_entry_t          rd_head;
  logic               unused_full;

  // Credits count reads from acceptance until their data leaves the
  // read-data FIFO, so neither FIFO can overflow.
  assign has_credit = credits < CRW'(RD_DEPTH);

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = s_axis_wr_tvalid[i] && (!s_axis_wr_tuser[i*CMD_W + CMD_RD_BIT] || has_credit);
    end
  end

  assign pick  = rr_find_first(8'(elig), int'(ptr), NUM_REQ);
  assign found = (pick >= 0);
  assign gidx  = TAG_W'(pick);

  always_comb begin
    grant = '0;
    if (found) grant[gidx] = 1'b1;
  end

  assign load             = !o_command_valid || i_controller_ready;
  assign s_axis_wr_tready = grant & {NUM_REQ{load}};
  assign accept           = found && load;
  assign sel_cmd          = s_axis_wr_tuser[int'(gidx)*CMD_W +: CMD_W];
  assign sel_data         = s_axis_wr_tdata[int'(gidx)*DATA_W +: DATA_W];
  assign sel_is_rd        = sel_cmd[CMD_RD_BIT];

  assign rd_inc = accept && sel_is_rd;
  assign rd_dec = rd_pop;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      o_command_valid <= 1'b0;
      o_command       <= '0;
      o_write_data    <= '0;
      ptr             <= '0;
      credits         <= '0;
      o_err           <= 1'b0;
    end else begin
      if (accept) begin
        o_command_valid <= 1'b1;
        o_command       <= sel_cmd;
        o_write_data    <= sel_data;
        ptr             <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
      end else if (i_controller_ready) begin
        o_command_valid <= 1'b0;
      end
      if (rd_inc && !rd_dec)      credits <= credits + 1'b1;
      else if (!rd_inc && rd_dec) credits <= credits - 1'b1;
      if (i_read_data_valid && tag_empty) o_err <= 1'b1;
    end
  end

  assign tag_push = rd_inc;
  // A beat with no outstanding read is dropped (and flagged above).
  assign tag_pop  = i_read_data_valid && !tag_empty;

  hbm_arb_fifo #(.WIDTH(TAG_W), .DEPTH(RD_DEPTH)) u_tag_fifo (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push  (tag_push),
    .din   (gidx),
    .pop   (tag_pop),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty)
  );

  always_comb begin
    rd_din      = '0;
    rd_din.tag  = tag_dout;
    rd_din.data = i_read_data;
  end

  hbm_arb_fifo #(.WIDTH($bits(rd_entry_t)), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push  (tag_pop),
    .din   (rd_din),
    .pop   (rd_pop),
    .dout  (rd_head),
    .full  (rd_full),
    .empty (rd_empty)
  );

  assign unused_full = tag_full | rd_full;

  // Only the head is presented, so a stalled requester blocks later returns.
  always_comb begin
    m_axis_rd_tvalid = '0;
    if (!rd_empty) m_axis_rd_tvalid[rd_head.tag] = 1'b1;
  end

  assign rd_pop          = !rd_empty && |(m_axis_rd_tvalid & m_axis_rd_tready);
  assign m_axis_rd_tdata = rd_head.data;
  assign m_axis_rd_tkeep = '1;
  assign m_axis_rd_tlast = 1'b0;

`ifdef HBM_ARB_STATS_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      o_stats <= '0;
    end else if (accept) begin
      o_stats[int'(gidx)*32 +: 32] <= o_stats[int'(gidx)*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hbm_cmd_arbiter.sv
// tb/tb_hbm_cmd_arbiter.sv - directed self-checking bench for hbm_cmd_arbiter
module tb_hbm_cmd_arbiter;

  localparam int NR = 4;
  localparam int CW = 25;
  localparam int DW = 1024;

  logic             ap_clk = 1'b0;
  logic             ap_rst = 1'b1;
  logic [NR-1:0]    tvalid = '0;
  logic [NR-1:0]    tready;
  logic [NR*CW-1:0] tuser  = '0;
  logic [NR*DW-1:0] tdata  = '0;
  logic             ctrl_ready = 1'b0;
  logic             cmd_valid;
  logic [CW-1:0]    cmd;
  logic [DW-1:0]    wdata;
  logic             rdv   = 1'b0;
  logic [DW-1:0]    rdata = '0;
  logic [NR-1:0]    rd_tvalid;
  logic [NR-1:0]    rd_tready = '0;
  logic [DW-1:0]    rd_tdata;
  logic [DW/8-1:0]  rd_tkeep;
  logic             rd_tlast;
  logic             err;

  int errors = 0;
  int checks = 0;
  int acc_cnt [NR];
  int rd_cnt  [NR];
  int xfer_cnt = 0;
  int base;
  logic [DW/8-1:0] all_keep;

  always #5 ap_clk = ~ap_clk;

  hbm_cmd_arbiter dut (
    .ap_clk             (ap_clk),
    .ap_rst             (ap_rst),
    .s_axis_wr_tvalid   (tvalid),
    .s_axis_wr_tready   (tready),
    .s_axis_wr_tuser    (tuser),
    .s_axis_wr_tdata    (tdata),
    .i_controller_ready (ctrl_ready),
    .o_command_valid    (cmd_valid),
    .o_command          (cmd),
    .o_write_data       (wdata),
    .i_read_data_valid  (rdv),
    .i_read_data        (rdata),
    .m_axis_rd_tvalid   (rd_tvalid),
    .m_axis_rd_tready   (rd_tready),
    .m_axis_rd_tdata    (rd_tdata),
    .m_axis_rd_tkeep    (rd_tkeep),
    .m_axis_rd_tlast    (rd_tlast),
    .o_err              (err)
  );

  always @(posedge ap_clk) begin
    if (!ap_rst) begin
      if (cmd_valid && ctrl_ready) xfer_cnt <= xfer_cnt + 1;
      for (int i = 0; i < NR; i++) begin
        if (tvalid[i] && tready[i])       acc_cnt[i] <= acc_cnt[i] + 1;
        if (rd_tvalid[i] && rd_tready[i]) rd_cnt[i]  <= rd_cnt[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [CW-1:0] cmd_of(input int i, input logic rd, input int n);
    return {rd, 16'h0, 4'(i), 4'(n)};
  endfunction

  function automatic logic [DW-1:0] wdat(input int i, input int n);
    logic [DW-1:0] v;
    v = '0;
    v[63:0] = {32'hC0DE0000, 24'(i), 8'(n)};
    return v;
  endfunction

  function automatic logic [DW-1:0] rdat(input int n);
    logic [DW-1:0] v;
    v = '0;
    v[63:0] = {32'hBEEF0000, 32'(n)};
    return v;
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rd, input int n);
    tvalid[i]           = 1'b1;
    tuser[i*CW +: CW]   = cmd_of(i, rd, n);
    tdata[i*DW +: DW]   = wdat(i, n);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int i, input logic rd, input int n);
    logic hit;
    hit = 1'b0;
    set_req(i, rd, n);
    for (int t = 0; t < 20; t++) begin
      @(negedge ap_clk);
      if (tready[i]) begin
        hit = 1'b1;
        break;
      end
    end
    tick();
    tvalid[i] = 1'b0;
    if (!hit) chk("issue_timeout", 0, 1);
  endtask

  task automatic ret(input int n);
    rdv   = 1'b1;
    rdata = rdat(n);
    tick();
    rdv   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, DW'(cmd_valid), 0);
    chk({tag, "_cmd"}, DW'(cmd), 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_rd_tvalid"}, DW'(rd_tvalid), 0);
    chk({tag, "_err"}, DW'(err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    all_keep = '1;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    chk_reset_state("reset");
    chk("reset_tready", DW'(tready), 0);
    chk("tkeep", DW'(rd_tkeep), DW'(all_keep));
    chk("tlast", DW'(rd_tlast), 0);

    // Test 1: four writers, controller always ready -> grants 0,1,2,3,0
    tick();
    ctrl_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, i);
    base = xfer_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      chk("t1_grant", DW'(tready), DW'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk("t1_valid", DW'(cmd_valid), 1);
        chk("t1_cmd", DW'(cmd), DW'(cmd_of((k - 1) % 4, 1'b0, (k - 1) % 4)));
        chk("t1_data", wdata, wdat((k - 1) % 4, (k - 1) % 4));
      end
      tick();
    end
    tvalid = '0;
    @(negedge ap_clk);
    chk("t1_last_valid", DW'(cmd_valid), 1);
    chk("t1_last_cmd", DW'(cmd), DW'(cmd_of(0, 1'b0, 0)));
    tick();
    @(negedge ap_clk);
    chk("t1_valid_drop", DW'(cmd_valid), 0);
    chk("t1_xfers", DW'(xfer_cnt - base), 5);

    // Test 2: requester 1 alone, controller stalls 5 cycles
    tick();
    ctrl_ready = 1'b0;
    base = xfer_cnt;
    set_req(1, 1'b0, 5);
    @(negedge ap_clk);
    chk("t2_first_ready", DW'(tready), DW'(4'b0010));
    tick();
    set_req(1, 1'b0, 6);
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      chk("t2_stall_valid", DW'(cmd_valid), 1);
      chk("t2_stall_cmd", DW'(cmd), DW'(cmd_of(1, 1'b0, 5)));
      chk("t2_stall_tready", DW'(tready), 0);
      tick();
    end
    chk("t2_no_xfer", DW'(xfer_cnt - base), 0);
    ctrl_ready = 1'b1;
    @(negedge ap_clk);
    chk("t2_ready_back", DW'(tready), DW'(4'b0010));
    tick();
    tvalid = '0;
    @(negedge ap_clk);
    chk("t2_next_cmd", DW'(cmd), DW'(cmd_of(1, 1'b0, 6)));
    chk("t2_next_data", wdata, wdat(1, 6));
    tick();
    @(negedge ap_clk);
    chk("t2_xfers", DW'(xfer_cnt - base), 2);

    // Test 3: requester 2 issues 9 reads, only 8 credits
    tick();
    base = acc_cnt[2];
    set_req(2, 1'b1, 9);
    repeat (12) tick();
    @(negedge ap_clk);
    chk("t3_accepted8", DW'(acc_cnt[2] - base), 8);
    chk("t3_credit_stall", DW'(tready), 0);
    tick();
    ret(50);
    @(negedge ap_clk);
    chk("t3_rd_tvalid", DW'(rd_tvalid), DW'(4'b0100));
    chk("t3_rd_tdata", rd_tdata, rdat(50));
    chk("t3_still_stalled", DW'(tready), 0);
    tick();
    rd_tready = 4'b0100;
    @(negedge ap_clk);
    chk("t3_stall_before_pop", DW'(tready), 0);
    tick();
    rd_tready = '0;
    @(negedge ap_clk);
    chk("t3_ninth_ready", DW'(tready), DW'(4'b0100));
    tick();
    tvalid = '0;
    chk("t3_accepted9", DW'(acc_cnt[2] - base), 9);
    rd_tready = '1;
    for (int k = 0; k < 8; k++) ret(100 + k);
    repeat (3) tick();
    chk("t3_drained", DW'(rd_cnt[2]), 9);
    chk("t3_no_err", DW'(err), 0);
    rd_tready = '0;

    // Test 4: reads from 3,0,3 return in issue order
    issue(3, 1'b1, 1);
    issue(0, 1'b1, 2);
    issue(3, 1'b1, 3);
    ret(200);
    ret(201);
    ret(202);
    @(negedge ap_clk);
    chk("t4_route0", DW'(rd_tvalid), DW'(4'b1000));
    chk("t4_data0", rd_tdata, rdat(200));
    tick();
    rd_tready = '1;
    @(negedge ap_clk);
    chk("t4_hold0", DW'(rd_tvalid), DW'(4'b1000));
    tick();
    @(negedge ap_clk);
    chk("t4_route1", DW'(rd_tvalid), DW'(4'b0001));
    chk("t4_data1", rd_tdata, rdat(201));
    tick();
    @(negedge ap_clk);
    chk("t4_route2", DW'(rd_tvalid), DW'(4'b1000));
    chk("t4_data2", rd_tdata, rdat(202));
    tick();
    @(negedge ap_clk);
    chk("t4_empty", DW'(rd_tvalid), 0);

    // Test 5: requester 0 stalls its read port while 8 returns arrive
    tick();
    rd_tready = '0;
    for (int k = 0; k < 8; k++) issue(0, 1'b1, k);
    for (int k = 0; k < 8; k++) ret(300 + k);
    set_req(0, 1'b1, 9);
    @(negedge ap_clk);
    chk("t5_full_stall", DW'(tready), 0);
    chk("t5_head_route", DW'(rd_tvalid), DW'(4'b0001));
    chk("t5_no_err", DW'(err), 0);
    tick();
    tvalid = '0;
    rd_tready = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      @(negedge ap_clk);
      chk("t5_drain_route", DW'(rd_tvalid), DW'(4'b0001));
      chk("t5_drain_data", rd_tdata, rdat(300 + k));
      tick();
    end
    @(negedge ap_clk);
    chk("t5_drain_empty", DW'(rd_tvalid), 0);

    // Test 6: stray return sets sticky error; reset mid-burst clears all
    tick();
    ret(400);
    @(negedge ap_clk);
    chk("t6_err_set", DW'(err), 1);
    repeat (3) tick();
    @(negedge ap_clk);
    chk("t6_err_sticky", DW'(err), 1);
    tick();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 10 + i);
    repeat (3) tick();
    ap_rst = 1'b1;
    tvalid = '0;
    @(negedge ap_clk);
    chk_reset_state("t6_rst");
    tick();
    tick();
    ap_rst = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 20 + i);
    @(negedge ap_clk);
    chk("t6_ptr_reset", DW'(tready), DW'(4'b0001));
    tick();
    tvalid = '0;
    @(negedge ap_clk);
    chk("t6_post_cmd", DW'(cmd), DW'(cmd_of(0, 1'b0, 20)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hbm_cmd_arbiter.md
Name: hbm_cmd_arbiter

Overview:
Shares one HBM controller command/read-data port between NUM_REQ traffic-generator AXI-Stream pairs.
- Round-robin arbitration of write-channel beats (command in tuser, write data in tdata) into a registered command stage.
- Tracks outstanding reads in issue order and routes returned read data to the originating requester's m_axis_rd.
- Sits between the traffic generators and the controller-facing adapter layer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CMD_W, 25, command width; bit 24 = 1 read, 0 write
DATA_W, 1024, read/write data width
RD_DEPTH, 8, read credits; depth of tag FIFO and read-data FIFO (power of 2)

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous reset, active-high
s_axis_wr_tvalid  in  NUM_REQ  per-requester command valid
s_axis_wr_tready  out  NUM_REQ  per-requester command ready
s_axis_wr_tuser  in  NUM_REQ*CMD_W  packed commands, requester i at [i*CMD_W +: CMD_W]
s_axis_wr_tdata  in  NUM_REQ*DATA_W  packed write data
i_controller_ready  in  1  controller accepts command
o_command_valid  out  1  registered command valid
o_command  out  CMD_W  registered command
o_write_data  out  DATA_W  registered write data
i_read_data_valid  in  1  controller read beat (no backpressure)
i_read_data  in  DATA_W  controller read data
m_axis_rd_tvalid  out  NUM_REQ  per-requester read valid
m_axis_rd_tready  in  NUM_REQ  per-requester read ready
m_axis_rd_tdata  out  DATA_W  shared read data, qualified by tvalid
m_axis_rd_tkeep  out  DATA_W/8  constant all ones
m_axis_rd_tlast  out  1  constant 0
o_err  out  1  sticky protocol error

Behaviour:
- Reset: o_command_valid=0, o_command/o_write_data=0, m_axis_rd_tvalid=0, o_err=0, RR pointer=0, FIFOs empty, credit count=0.
- load = !o_command_valid || i_controller_ready.
- Eligible(i) = tvalid[i] && (cmd[i][24]==0 || credits < RD_DEPTH).
- Grant: first eligible requester at or after the RR pointer, wrapping. Exactly one grant, combinational from tvalid/pointer/credits.
- tready[i] = grant[i] && load. No ready toward a non-granted requester.
- Accept (tvalid&&tready):
  - Register the command and data; o_command_valid=1 next cycle, giving 1-cycle latency.
  - Pointer = grant index + 1, modulo NUM_REQ.
  - If the command is a read: push the grant index to the tag FIFO and increment credits.
- Transfer on o_command_valid && i_controller_ready. If no accept occurs in the same cycle, o_command_valid drops to 0.
- Back-to-back: a transfer and a new accept in the same cycle give continuous valid.
- Read return: on i_read_data_valid, pop the tag FIFO and push {tag,data} into the read-data FIFO.
  - If the tag FIFO is empty: drop the beat and set o_err.
  - Credits guarantee no read-data FIFO overflow.
- Read output: when the FIFO is non-empty, m_axis_rd_tvalid[head.tag]=1 and all other bits are 0; tdata = head.data.
  - Pop on handshake; credits decrement on pop.
  - Head-of-line blocking is intended: returns stay in issue order.
- Simultaneous read accept and pop: credits unchanged.
- A FIFO push and pop in the same cycle are both allowed, including when full with a pop present.
- Reset mid-operation clears all state. The controller must be reset together with this block; stale returns after reset set o_err.
- No combinational path from i_controller_ready to o_command_valid.

Optional Feature:
HBM_ARB_STATS_EN
- Defined: adds output o_stats (NUM_REQ*32 bits) with one wrapping 32-bit counter per requester.
  - A counter increments on each accepted command from that requester.
  - Counters clear on reset.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hbm_arb_pkg:
  - CMD_RD_BIT=24.
  - Typedef rd_entry_t = {tag [$clog2(NUM_REQ)-1:0], data [DATA_W-1:0]}.
  - A function for round-robin find-first from the pointer.
- Sub-module hbm_arb_fifo: generic synchronous FIFO (WIDTH, DEPTH, full/empty, push/pop, simultaneous push/pop). Instantiated twice: tag FIFO and read-data FIFO.

Test Plan:
1. All 4 requesters hold writes, controller always ready → grants 0,1,2,3,0 on consecutive cycles; o_command_valid continuous; data matches source.
2. Requester 1 only, controller ready low for 5 cycles → command held stable; tready[1]=0 during the stall; single transfer once ready is high.
3. Requester 2 issues 9 reads with RD_DEPTH=8 and no returns → 8 accepted; 9th stalls until one read-data FIFO pop.
4. Reads issued from requesters 3,0,3 → returned beats D0,D1,D2 appear on m_axis_rd_tvalid bits 3,0,3 in order.
5. m_axis_rd_tready[0]=0 while returns continue → FIFO fills to 8 with no loss; draining delivers all beats.
6. i_read_data_valid with no outstanding reads → o_err=1 and stays 1 until ap_rst; ap_rst mid-burst → all outputs return to reset values.
